// File: rtl/evf_tx_pkg.sv
// evf_tx_pkg: shared constants and types for the EVF transmit framer.
//   K28_5 / NULL_CODE  : special low-byte values (comma, "no event")
//   KFLAG_*            : dataIsK patterns for comma and data words
//   evf_word_t         : one 16-bit MGT word {dbus byte, event byte}
//   evf_sel_e          : which source feeds the low byte this cycle
package evf_tx_pkg;

  localparam logic [7:0] K28_5       = 8'hBC;
  localparam logic [7:0] NULL_CODE   = 8'h00;
  localparam logic [1:0] KFLAG_COMMA = 2'b01;
  localparam logic [1:0] KFLAG_DATA  = 2'b00;

  typedef struct packed {
    logic [7:0] dbus;
    logic [7:0] ev;
  } evf_word_t;

  // Listed in priority order.
  typedef enum logic [1:0] {
    SEL_FLUSH,
    SEL_COMMA,
    SEL_EVENT,
    SEL_IDLE
  } evf_sel_e;

endpackage

// File: rtl/evf_event_fifo.sv
// evf_event_fifo: synchronous event-code FIFO with show-ahead head.
//   clk, rst_n  : clock, async active-low reset
//   flush_i     : empties the FIFO (wins over wr_i/rd_i)
//   wr_i/wdata_i: push one code; caller guarantees !full_o or rd_i
//   rd_i        : pop head_o; caller guarantees !empty_o
//   head_o      : oldest queued code, valid while !empty_o
//   level_o     : occupancy 0..2**AW
//   full_o/empty_o
module evf_event_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  input  logic          rd_i,
  output logic [7:0]    head_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  // Extra MSB on each pointer separates full from empty when the
  // address bits match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_i) wptr_q <= wptr_q + ONE;
      if (rd_i) rptr_q <= rptr_q + ONE;
    end
  end

  // Full-with-pop overwrites the slot being read; the head is consumed at
  // this same edge, so the old value is never needed afterwards.
  always_ff @(posedge clk) begin
    if (wr_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/evf_tx_framer.sv
// evf_tx_framer: builds the 16-bit 8b10b input word stream for the EVF MGT.
//   txClk, txRst_n   : TX user clock, async active-low reset
//   mgtReady         : link up; low forces commas and flushes the queue
//   evStrobe/evCode  : event code input; evReady = !full && mgtReady
//   dbus             : distributed-bus byte, sent in the high byte each word
//   clearStatus      : clears evOverflow/dropCount (a same-cycle drop wins)
//   txCode/dataIsK   : registered word and K flags to the MGT
//   fifoLevel        : event FIFO occupancy
//   evOverflow       : sticky drop flag; dropCount: saturating drop count
module evf_tx_framer
  import evf_tx_pkg::*;
#(
  parameter int FIFO_AW      = 4,
  parameter int COMMA_PERIOD = 32
) (
  input  logic               txClk,
  input  logic               txRst_n,
  input  logic               mgtReady,
  input  logic               evStrobe,
  input  logic [7:0]         evCode,
  output logic               evReady,
  input  logic [7:0]         dbus,
  input  logic               clearStatus,
  output logic [15:0]        txCode,
  output logic [1:0]         dataIsK,
  output logic [FIFO_AW:0]   fifoLevel,
  output logic               evOverflow,
  output logic [7:0]         dropCount
);

  localparam logic [7:0] CNT_LAST = 8'(COMMA_PERIOD - 1);

  evf_sel_e   sel;
  evf_word_t  word_q, word_d;
  logic [1:0] k_q, k_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [7:0] drops_q, drops_d;
  logic       run_q;

  logic       code_ok, fifo_wr, fifo_rd, drop;
  logic       full, empty;
  logic [7:0] head;

  evf_event_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (txClk),
    .rst_n   (txRst_n),
    .flush_i (!mgtReady),
    .wr_i    (fifo_wr),
    .wdata_i (evCode),
    .rd_i    (fifo_rd),
    .head_o  (head),
    .level_o (fifoLevel),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    sel = SEL_IDLE;
    if (!mgtReady)              sel = SEL_FLUSH;
    else if (cnt_q == CNT_LAST) sel = SEL_COMMA;
    else if (!empty)            sel = SEL_EVENT;
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign fifo_rd = (sel == SEL_EVENT);
  assign code_ok = evStrobe && (evCode != NULL_CODE) && mgtReady;
  assign fifo_wr = code_ok && (!full || fifo_rd);
  assign drop    = code_ok && full && !fifo_rd;

  always_comb begin
    word_d.dbus = dbus;
    word_d.ev   = NULL_CODE;
    k_d         = KFLAG_DATA;
    cnt_d       = cnt_q + 8'd1;
    case (sel)
      SEL_FLUSH, SEL_COMMA: begin
        word_d.ev = K28_5;
        k_d       = KFLAG_COMMA;
        cnt_d     = '0;
      end
      SEL_EVENT: word_d.ev = head;
      default:   ;
    endcase
  end

  // Clear first, then apply the drop, so a coincident drop leaves count 1.
  always_comb begin
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (clearStatus) begin
      ovf_d   = 1'b0;
      drops_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_d != 8'hFF) drops_d = drops_d + 8'd1;
    end
  end

  always_ff @(posedge txClk or negedge txRst_n) begin
    if (!txRst_n) begin
      word_q  <= '{dbus: 8'h00, ev: K28_5};
      k_q     <= KFLAG_COMMA;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
      run_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
      run_q   <= 1'b1;
    end
  end

  // run_q keeps evReady low while reset is held.
  assign evReady    = run_q && mgtReady && !full;
  assign txCode     = word_q;
  assign dataIsK    = k_q;
  assign evOverflow = ovf_q;
  assign dropCount  = drops_q;

endmodule

// File: tb/tb_evf_tx_framer.sv
module tb_evf_tx_framer;
  import evf_tx_pkg::*;

  localparam int P0    = 32;
  localparam int P1    = 2;
  localparam int DEPTH = 16;

  logic txClk = 1'b0;
  always #5 txClk = ~txClk;

  logic       txRst_n, mgtReady, evStrobe, clearStatus;
  logic [7:0] evCode, dbus;

  logic [15:0] txc  [2];
  logic [1:0]  dk   [2];
  logic [4:0]  lvl  [2];
  logic        rdy  [2];
  logic        ovf  [2];
  logic [7:0]  dcnt [2];

  evf_tx_framer #(.FIFO_AW(4), .COMMA_PERIOD(P0)) dut0 (
    .txClk(txClk), .txRst_n(txRst_n), .mgtReady(mgtReady), .evStrobe(evStrobe),
    .evCode(evCode), .evReady(rdy[0]), .dbus(dbus), .clearStatus(clearStatus),
    .txCode(txc[0]), .dataIsK(dk[0]), .fifoLevel(lvl[0]), .evOverflow(ovf[0]),
    .dropCount(dcnt[0]));

  evf_tx_framer #(.FIFO_AW(4), .COMMA_PERIOD(P1)) dut1 (
    .txClk(txClk), .txRst_n(txRst_n), .mgtReady(mgtReady), .evStrobe(evStrobe),
    .evCode(evCode), .evReady(rdy[1]), .dbus(dbus), .clearStatus(clearStatus),
    .txCode(txc[1]), .dataIsK(dk[1]), .fifoLevel(lvl[1]), .evOverflow(ovf[1]),
    .dropCount(dcnt[1]));

  int ncmp = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending codes plus a words-since-comma count.
  logic [7:0]  mq [2][$];
  int          mcnt [2];
  logic [15:0] mtx  [2];
  logic [1:0]  mk   [2];
  bit          movf [2];
  int          mdrop[2];
  bit          mrun [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mcnt[i] = 0; mtx[i] = 16'h00BC; mk[i] = 2'b01;
      movf[i] = 0; mdrop[i] = 0; mrun[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] ev;
      bit k, dropped;
      int per;
      per = (i == 0) ? P0 : P1;
      dropped = 0;
      if (!mgtReady) begin
        mq[i].delete(); mcnt[i] = 0; ev = 8'hBC; k = 1;
      end else begin
        if (mcnt[i] == per - 1) begin
          ev = 8'hBC; k = 1; mcnt[i] = 0;
        end else begin
          k = 0; mcnt[i]++;
          ev = (mq[i].size() > 0) ? mq[i].pop_front() : 8'h00;
        end
        if (evStrobe && evCode != 8'h00) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(evCode);
          else dropped = 1;
        end
      end
      mtx[i] = {dbus, ev};
      mk[i]  = {1'b0, k};
      if (clearStatus) begin movf[i] = 0; mdrop[i] = 0; end
      if (dropped) begin movf[i] = 1; if (mdrop[i] < 255) mdrop[i]++; end
      mrun[i] = 1;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("txCode%0d", i),  32'(txc[i]), 32'(mtx[i]));
      check($sformatf("dataIsK%0d", i), 32'(dk[i]),  32'(mk[i]));
      check($sformatf("level%0d", i),   32'(lvl[i]), 32'(mq[i].size()));
      check($sformatf("evReady%0d", i), 32'(rdy[i]),
            32'(mrun[i] && mgtReady && (mq[i].size() < DEPTH)));
      check($sformatf("ovf%0d", i),     32'(ovf[i]), 32'(movf[i]));
      check($sformatf("drops%0d", i),   32'(dcnt[i]), 32'(mdrop[i]));
    end
  endtask

  task automatic step();
    @(posedge txClk);
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    bit          stb;
    logic [7:0]  code;
    logic [15:0] etx;
    logic [1:0]  ek;
    logic [4:0]  elvl;
  } vec_t;
  vec_t tv[34];

  initial begin
    int kcount, ndeliv;
    logic [7:0] last;
    bit saw_full;

    for (int r = 0; r < 34; r++) tv[r] = '{0, 8'h00, 16'h5A00, 2'b00, 5'd0};
    tv[1]  = '{1, 8'h7E, 16'h5A00, 2'b00, 5'd1};
    tv[2]  = '{0, 8'h00, 16'h5A7E, 2'b00, 5'd0};
    tv[30] = '{1, 8'h7E, 16'h5A00, 2'b00, 5'd1};
    tv[31] = '{0, 8'h00, 16'h5ABC, 2'b01, 5'd1};
    tv[32] = '{0, 8'h00, 16'h5A7E, 2'b00, 5'd0};

    txRst_n = 0; mgtReady = 1; evStrobe = 0; evCode = 0; dbus = 8'h5A; clearStatus = 0;
    model_reset();
    #12;
    check("rst_txCode", 32'(txc[0]), 32'h00BC);
    check("rst_dataIsK", 32'(dk[0]), 32'h1);
    check("rst_evReady", 32'(rdy[0]), 32'h0);
    compare_all();
    @(negedge txClk) txRst_n = 1;

    // Latency, comma collision: table of per-cycle inputs and outputs.
    for (int r = 0; r < 34; r++) begin
      evStrobe = tv[r].stb; evCode = tv[r].code;
      step();
      check($sformatf("tv%0d_tx", r),  32'(txc[0]), 32'(tv[r].etx));
      check($sformatf("tv%0d_k", r),   32'(dk[0]),  32'(tv[r].ek));
      check($sformatf("tv%0d_lvl", r), 32'(lvl[0]), 32'(tv[r].elvl));
    end
    evStrobe = 0; evCode = 0;

    // Idle: exactly two commas in 64 consecutive words at period 32.
    kcount = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (dk[0] == 2'b01) kcount++;
    end
    check("idle_commas", 32'(kcount), 32'd2);

    // Overload at period 2.
    ndeliv = 0; last = 8'h00; saw_full = 0;
    for (int c = 1; c <= 110; c++) begin
      evStrobe = (c <= 60); evCode = (c <= 60) ? 8'(c) : 8'h00;
      step();
      if (lvl[1] == 5'd16 && !rdy[1]) saw_full = 1;
      if (dk[1] == 2'b00 && txc[1][7:0] != 8'h00) begin
        check("t4_order", 32'(txc[1][7:0] > last), 32'd1);
        last = txc[1][7:0];
        ndeliv++;
      end
    end
    evStrobe = 0; evCode = 0;
    check("t4_full_seen", 32'(saw_full), 32'd1);
    check("t4_ovf", 32'(ovf[1]), 32'd1);
    check("t4_drops", 32'(dcnt[1]), 32'(60 - ndeliv));
    clearStatus = 1; step(); clearStatus = 0;
    check("t4_clr_ovf", 32'(ovf[1]), 32'd0);
    check("t4_clr_drops", 32'(dcnt[1]), 32'd0);

    // Link drop with events queued.
    for (int c = 0; c < 5; c++) begin
      evStrobe = 1; evCode = 8'hA1 + 8'(c); step();
    end
    mgtReady = 0; evCode = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_comma", 32'({dk[1], txc[1][7:0]}), 32'h1BC);
      check("t5_lvl", 32'(lvl[1]), 32'd0);
    end
    mgtReady = 1; evCode = 8'h00;
    for (int c = 0; c < 10; c++) step();
    check("t5_null_lvl", 32'(lvl[1]), 32'd0);
    evStrobe = 0;

    // Async reset mid-burst.
    for (int c = 0; c < 6; c++) begin
      evStrobe = 1; evCode = 8'($urandom_range(1, 255)); step();
    end
    #2 txRst_n = 0;
    #1;
    check("t6_txCode", 32'(txc[1]), 32'h00BC);
    check("t6_k", 32'(dk[1]), 32'h1);
    check("t6_lvl", 32'(lvl[1]), 32'd0);
    check("t6_rdy", 32'(rdy[1]), 32'd0);
    model_reset();
    compare_all();
    evStrobe = 0;
    @(negedge txClk) txRst_n = 1;

    // Saturation of dropCount at period 2.
    for (int c = 0; c < 700; c++) begin
      evStrobe = 1; evCode = 8'($urandom_range(1, 255)); dbus = 8'($urandom); step();
    end
    check("sat_drops", 32'(dcnt[1]), 32'hFF);
    evStrobe = 0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) mgtReady = ~mgtReady;
      evStrobe    = ($urandom_range(0, 9) < 7);
      evCode      = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      dbus        = 8'($urandom);
      clearStatus = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
